mem_stage: RTL
==============

Name: mem_stage

Overview:
- Memory pipeline stage of the RV32IM core. Consumes the registered execute-stage outputs: data address, size, read/write flags, load op, destination register and ALU/store-data result.
- Runs the data-bus transaction: request/grant, then read-data valid for loads.
- Aligns store data, extracts and sign/zero-extends load data, and registers the writeback fields.
- Raises a stall toward the hazard unit until the access completes.

Parameters:
DATA_WIDTH, 32, data/address width (only 32 supported)
REG_ADDR_WIDTH, 5, register index width

Ports:
clk  in  1  clock
rst_n  in  1  reset
m_regfile_waddr_i  in  5  destination register from execute
m_regfile_rd_i  in  32  ALU result, or store data when m_data_wr_i=1
m_regfile_wr_i  in  1  register write enable from execute
m_data_wr_i  in  1  store request
m_data_rd_i  in  1  load request
m_data_addr_i  in  32  byte address
m_data_be_i  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved (treated as word)
m_is_load_store_i  in  1  instruction is a memory access
m_LOAD_op_i  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
stall_general_i  in  1  global pipeline stall (includes this block's stall_mem_o)
data_req_o  out  1  bus request
data_gnt_i  in  1  bus grant (address phase accepted)
data_we_o  out  1  bus write
data_addr_o  out  32  word-aligned address {addr[31:2],2'b00}
data_be_o  out  4  byte lane enables
data_wdata_o  out  32  lane-aligned write data
data_rdata_i  in  32  read data
data_rvalid_i  in  1  read data valid
stall_mem_o  out  1  memory stage busy
misalign_o  out  1  misaligned access flag
w_regfile_waddr_o  out  5  writeback register index
w_regfile_wdata_o  out  32  writeback data
w_regfile_wr_o  out  1  writeback enable

Behaviour:
- Reset is asynchronous, active-low on rst_n; clock is clk.
- Reset values: all outputs 0; FSM in IDLE; load-hold register 0.
- access = m_is_load_store_i & (m_data_rd_i | m_data_wr_i). If both rd and wr are set, the access is a store.
- FSM states:
  - IDLE: if access, data_req_o is asserted combinationally in the same cycle.
    - gnt=1 and store: go to DONE.
    - gnt=1 and load: go to WAIT_R.
    - gnt=0: go to REQ.
  - REQ: hold data_req_o and all bus fields stable until gnt.
    - gnt=1 and store: go to DONE.
    - gnt=1 and load: go to WAIT_R.
  - WAIT_R: data_req_o=0. On rvalid, capture the extended load data into the hold register and go to DONE.
  - DONE: no request. Go to IDLE on the first cycle with stall_general_i=0. This prevents re-issue while the pipeline is frozen by other sources.
- A simultaneous rvalid and new request cannot occur: one outstanding access only. rvalid outside WAIT_R is ignored.
- stall_mem_o = access & (state != DONE) & !(rvalid in WAIT_R) & !(store gnt in IDLE/REQ). Consequences:
  - A store granted in its first cycle costs 0 stall cycles.
  - A load costs at least 1 stall cycle.
- data_be_o (from addr[1:0]):
  - byte: 4'b0001 << addr[1:0]
  - half: addr[1] ? 4'b1100 : 4'b0011
  - word: 4'b1111
- data_wdata_o:
  - byte: replicate rd_i[7:0] into all four lanes
  - half: replicate rd_i[15:0] into both halves
  - word: rd_i
- Load extract: shift data_rdata_i right by 8*addr[1:0] (half uses addr[1] only), then:
  - LB/LH: sign-extend
  - LBU/LHU: zero-extend
  - LW: unchanged
  - other codes: zero
- Writeback register updates only when stall_general_i=0:
  - waddr <= m_regfile_waddr_i
  - wr <= m_regfile_wr_i & !m_data_wr_i
  - wdata <= (load ? extracted data : m_regfile_rd_i)
  - The extracted data comes from the live data_rdata_i in the rvalid cycle, otherwise from the hold register in DONE.
- A non-memory instruction passes straight through with 1-cycle latency.
- Reset mid-transaction: returns to IDLE and drops req at once. The bus is expected to be reset together.

Optional Feature:
- MEM_MISALIGN_CHECK_EN defined:
  - A half access with addr[0]=1, or a word access with addr[1:0]!=0, asserts misalign_o (combinational, while the access is present).
  - No bus request is issued and stall_mem_o=0.
  - The writeback wr bit is forced to 0.
- Not defined:
  - misalign_o is tied to 0.
  - Low address bits are ignored as specified above: half uses addr[1], word ignores addr[1:0].

Test Plan:
- SB rd_i=0x000000A5, addr=0x1003, gnt same cycle -> req=1, we=1, be=1000, wdata=0xA5A5A5A5, data_addr=0x1000, stall_mem_o=0, w_regfile_wr_o=0.
- LB addr=0x2001, gnt after 2 cycles, rvalid 1 cycle later with rdata=0x1234_80FF -> stall_mem_o high 3 cycles, then w_regfile_wdata_o=0xFFFFFF80, w_regfile_wr_o=1.
- LHU addr=0x2002, rdata=0x8001_7777 -> wdata=0x00008001. Same with LH -> 0xFFFF8001.
- Load completes while stall_general_i is held high 3 more cycles -> exactly one req pulse, and the writeback receives the held value when the stall releases.
- ADD result 0x55 to x7, no memory access -> w_regfile_waddr_o=7, w_regfile_wdata_o=0x55 next cycle, data_req_o=0 throughout.
- rst_n low while in WAIT_R -> req=0, state IDLE, all outputs 0. With MEM_MISALIGN_CHECK_EN: LW addr=0x3002 -> misalign_o=1, no req, w_regfile_wr_o=0.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: memory pipeline stage of the RV32IM core.
// Runs one data-bus access at a time (request/grant, then read-data valid
// for loads). It lane-aligns store data, extracts and extends load data, and
// registers the writeback fields. It holds stall_mem_o until the access completes.
// Optional feature: define MEM_MISALIGN_CHECK_EN to flag misaligned half/word
// accesses. A flagged access is not issued and its register write is suppressed.
module mem_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [REG_ADDR_WIDTH-1:0] m_regfile_waddr_i,
  input  logic [DATA_WIDTH-1:0]     m_regfile_rd_i,
  input  logic                      m_regfile_wr_i,
  input  logic                      m_data_wr_i,
  input  logic                      m_data_rd_i,
  input  logic [DATA_WIDTH-1:0]     m_data_addr_i,
  input  logic [1:0]                m_data_be_i,
  input  logic                      m_is_load_store_i,
  input  logic [2:0]                m_LOAD_op_i,
  input  logic                      stall_general_i,
  output logic                      data_req_o,
  input  logic                      data_gnt_i,
  output logic                      data_we_o,
  output logic [DATA_WIDTH-1:0]     data_addr_o,
  output logic [3:0]                data_be_o,
  output logic [DATA_WIDTH-1:0]     data_wdata_o,
  input  logic [DATA_WIDTH-1:0]     data_rdata_i,
  input  logic                      data_rvalid_i,
  output logic                      stall_mem_o,
  output logic                      misalign_o,
  output logic [REG_ADDR_WIDTH-1:0] w_regfile_waddr_o,
  output logic [DATA_WIDTH-1:0]     w_regfile_wdata_o,
  output logic                      w_regfile_wr_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t state_reg, state_next;

  logic                  is_store;
  logic                  is_load;
  logic                  access;
  logic                  misalign;
  logic                  bus_access;
  logic                  size_byte;
  logic                  size_half;
  logic                  req_next;
  logic                  stall_next;
  logic [3:0]            be_lane;
  logic [DATA_WIDTH-1:0] wdata_lane;
  logic [DATA_WIDTH-1:0] byte_shift;
  logic [DATA_WIDTH-1:0] half_shift;
  logic [DATA_WIDTH-1:0] load_ext;
  logic [DATA_WIDTH-1:0] load_hold_reg;
  logic                  rvalid_hit;

  // A request with both rd and wr set is treated as a store.
  assign is_store  = m_data_wr_i;
  assign is_load   = m_data_rd_i & ~m_data_wr_i;
  assign access    = m_is_load_store_i & (m_data_rd_i | m_data_wr_i);
  assign size_byte = (m_data_be_i == 2'b00);
  assign size_half = (m_data_be_i == 2'b01);

`ifdef MEM_MISALIGN_CHECK_EN
  // Half must be 2-byte aligned, word (and reserved size) 4-byte aligned.
  assign misalign = access & ((size_half & m_data_addr_i[0]) |
                              (m_data_be_i[1] & (m_data_addr_i[1:0] != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  assign bus_access = access & ~misalign;
  assign rvalid_hit = (state_reg == WAIT_R) & data_rvalid_i;

  // Bus transaction FSM: state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Bus transaction FSM: next state, request and stall.
  always_comb begin
    state_next = state_reg;
    req_next   = 1'b0;
    stall_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus_access) begin
          req_next = 1'b1;
          if (data_gnt_i) begin
            state_next = is_store ? DONE : WAIT_R;
            stall_next = ~is_store;
          end else begin
            state_next = REQ;
            stall_next = 1'b1;
          end
        end
      end
      REQ: begin
        req_next = 1'b1;
        if (data_gnt_i) begin
          state_next = is_store ? DONE : WAIT_R;
          stall_next = bus_access & ~is_store;
        end else begin
          stall_next = bus_access;
        end
      end
      WAIT_R: begin
        if (data_rvalid_i) state_next = DONE;
        stall_next = bus_access & ~data_rvalid_i;
      end
      DONE: begin
        // Stay here while anything freezes the pipeline so the access is not re-issued.
        if (!stall_general_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Byte-lane enables from size and low address bits.
  always_comb begin
    be_lane = 4'b1111;
    if (size_byte)      be_lane = 4'b0001 << m_data_addr_i[1:0];
    else if (size_half) be_lane = m_data_addr_i[1] ? 4'b1100 : 4'b0011;
  end

  // Store data replicated so every enabled lane carries the right byte.
  for (genvar gi = 0; gi < 4; gi++) begin : g_wlane
    assign wdata_lane[gi*8 +: 8] = size_byte ? m_regfile_rd_i[7:0] :
                                   size_half ? m_regfile_rd_i[(gi%2)*8 +: 8] :
                                               m_regfile_rd_i[gi*8 +: 8];
  end

  // Outputs are forced low while reset is held; bus fields only qualify a request.
  assign data_req_o   = req_next & rst_n;
  assign stall_mem_o  = stall_next & rst_n;
  assign misalign_o   = misalign & rst_n;
  assign data_we_o    = data_req_o & is_store;
  assign data_addr_o  = data_req_o ? {m_data_addr_i[DATA_WIDTH-1:2], 2'b00} : '0;
  assign data_be_o    = data_req_o ? be_lane : 4'b0000;
  assign data_wdata_o = data_req_o ? wdata_lane : '0;

  assign byte_shift = data_rdata_i >> {m_data_addr_i[1:0], 3'b000};
  assign half_shift = data_rdata_i >> {m_data_addr_i[1], 4'b0000};

  // Load extraction and sign/zero extension of the live read data.
  always_comb begin
    load_ext = '0;
    case (m_LOAD_op_i)
      3'b000: load_ext = {{24{byte_shift[7]}}, byte_shift[7:0]};
      3'b001: load_ext = {{16{half_shift[15]}}, half_shift[15:0]};
      3'b010: load_ext = data_rdata_i;
      3'b100: load_ext = {24'd0, byte_shift[7:0]};
      3'b101: load_ext = {16'd0, half_shift[15:0]};
      default: load_ext = '0;
    endcase
  end

  // Hold the extracted load data so a frozen pipeline can collect it later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          load_hold_reg <= '0;
    else if (rvalid_hit) load_hold_reg <= load_ext;
  end

  // Writeback register, advanced only when the pipeline moves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_regfile_waddr_o <= '0;
      w_regfile_wdata_o <= '0;
      w_regfile_wr_o    <= 1'b0;
    end else if (!stall_general_i) begin
      w_regfile_waddr_o <= m_regfile_waddr_i;
      w_regfile_wr_o    <= m_regfile_wr_i & ~m_data_wr_i & ~misalign;
      if (access & is_load)
        w_regfile_wdata_o <= rvalid_hit ? load_ext : load_hold_reg;
      else
        w_regfile_wdata_o <= m_regfile_rd_i;
    end
  end

endmodule
